// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
// Optional clear-on-reset sequence is enabled with the MEM_ARB_CLEAR_EN macro.
package mem_arb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int NUM_WORDS  = 1 << DEF_ADDR_W;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  // Sub-phases of one word inside the CLEAR sweep
  localparam logic [1:0] CLR_SETUP   = 2'd0;
  localparam logic [1:0] CLR_ACCESS  = 2'd1;
  localparam logic [1:0] CLR_RELEASE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_CLEAR   = 3'd4
  } state_e;

endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: combinational two-way round-robin pick.
// A lone requester always wins; on a tie the prio input decides.
module mem_arb_rr2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       win_valid,
  output logic       win_id
);

  // Winner selection from the current request vector
  always_comb begin
    win_valid = |req;
    win_id    = 1'b0;
    unique case (req)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = prio;
      default: win_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and three-phase sequencer for the
// 8x8 memory unit. Define MEM_ARB_CLEAR_EN to zero the memory after reset.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_op,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  state_e            state_q, state_d;
  logic              lat_we, lat_id;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              prio_q;
  logic [1:0]        done_q;
  logic [DATA_W-1:0] rdata_q;
  logic              win_valid, win_id;

  mem_arb_rr2 u_rr (
    .req       (req),
    .prio      (prio_q),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

`ifdef MEM_ARB_CLEAR_EN
  localparam state_e RST_STATE = ST_CLEAR;
  logic [1:0]        clr_phase;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_last;

  assign clr_last = (clr_phase == CLR_RELEASE) && (clr_addr == {ADDR_W{1'b1}});

  // Clear sweep counters: three sub-phases per word, ascending address
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_phase <= CLR_SETUP;
      clr_addr  <= '0;
    end else if (state_q == ST_CLEAR) begin
      if (clr_phase == CLR_RELEASE) begin
        clr_phase <= CLR_SETUP;
        clr_addr  <= clr_addr + ADDR_W'(1);
      end else begin
        clr_phase <= clr_phase + 2'd1;
      end
    end
  end
`else
  localparam state_e RST_STATE = ST_IDLE;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RST_STATE;
    else     state_q <= state_d;
  end

  // Next-state logic; requests are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (win_valid) state_d = ST_SETUP;
      ST_SETUP:   state_d = ST_ACCESS;
      ST_ACCESS:  state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
`ifdef MEM_ARB_CLEAR_EN
      ST_CLEAR:   if (clr_last) state_d = ST_IDLE;
`else
      ST_CLEAR:   state_d = ST_IDLE;
`endif
      default:    state_d = ST_IDLE;
    endcase
  end

  // Memory-side and handshake outputs; the bus is driven from the latch in
  // every normal state so address/op stay stable around the select pulse
  always_comb begin
    gnt         = 2'b00;
    busy        = (state_q != ST_IDLE);
    mem_select  = (state_q == ST_ACCESS);
    mem_op      = lat_we;
    mem_address = lat_addr;
    mem_in      = lat_data;
    if (state_q == ST_SETUP) gnt[lat_id] = 1'b1;
`ifdef MEM_ARB_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      mem_select  = (clr_phase == CLR_ACCESS);
      mem_op      = OP_WRITE;
      mem_address = clr_addr;
      mem_in      = '0;
    end
`endif
  end

  // Command latch: capture the winner's command when a grant is made
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we   <= OP_READ;
      lat_id   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (state_q == ST_IDLE && win_valid) begin
      lat_id   <= win_id;
      lat_we   <= win_id ? we[1]  : we[0];
      lat_addr <= win_id ? addr1  : addr0;
      lat_data <= win_id ? wdata1 : wdata0;
    end
  end

  // Completion: done pulse, read capture and priority hand-over at RELEASE
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= 2'b00;
      rdata_q <= '0;
      prio_q  <= 1'b0;
    end else begin
      done_q <= 2'b00;
      if (state_q == ST_RELEASE) begin
        done_q[lat_id] <= 1'b1;
        prio_q         <= ~lat_id;
        if (lat_we == OP_READ) rdata_q <= mem_out;
      end
    end
  end

  assign done  = done_q;
  assign rdata = rdata_q;

endmodule
